// File: rtl/sram_access_ctrl.sv
// rtl/sram_access_ctrl.sv - host-to-SRAM sequencer with aspect-ratio mapping and read-modify-write
module sram_access_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  conf,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [14:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        mem_en,
    output logic        mem_we,
    output logic [9:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_RSP
    } state_t;

    state_t state, state_nxt;

    // Request-side decode: unused encodings fall back to the full-width mapping
    logic [2:0]  conf_eff;
    logic [14:0] addr_shr;
    logic [4:0]  lane_in;
    logic        accept;

    assign conf_eff = (conf > 3'd5) ? 3'd0 : conf;
    assign addr_shr = req_addr >> conf_eff;
    assign lane_in  = req_addr[4:0] & 5'((6'd1 << conf_eff) - 6'd1);
    assign accept   = (state == S_IDLE) && req_valid;

    // Latched operation context for the in-flight request
    logic [2:0]  c_q;
    logic        we_q;
    logic [9:0]  row_q;
    logic [4:0]  lane_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;

    // Lane geometry derived from the latched width
    logic [5:0]  width;
    logic [31:0] lane_mask;
    logic [4:0]  shamt;
    logic [4:0]  wrap;
    logic [31:0] lane_val;
    logic [31:0] merged;
    logic [31:0] rep;

    assign width     = 6'd32 >> c_q;
    assign lane_mask = 32'hFFFF_FFFF >> (6'd32 - width);
    assign shamt     = 5'(lane_q << (3'd5 - c_q));
    assign wrap      = 5'(width - 6'd1);
    assign lane_val  = (mem_rdata >> shamt) & lane_mask;
    assign merged    = (mem_rdata & ~(lane_mask << shamt)) | ((wdata_q & lane_mask) << shamt);

    // Replicate the right-justified lane across the whole word
    always_comb begin
        rep = '0;
        for (int i = 0; i < 32; i++) begin
            rep[i] = lane_val[5'(i) & wrap];
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture request context at accept so later conf changes cannot disturb it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q     <= 3'd0;
            we_q    <= 1'b0;
            row_q   <= 10'd0;
            lane_q  <= 5'd0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            c_q     <= conf_eff;
            we_q    <= req_we;
            row_q   <= addr_shr[9:0];
            lane_q  <= lane_in;
            wdata_q <= req_wdata;
        end
    end

    // Read data lands in CAP: either becomes the response or the merged write word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data <= 32'd0;
            merge_q  <= 32'd0;
        end else if (state == S_CAP) begin
            if (we_q) begin
                merge_q <= merged;
            end else begin
                rsp_data <= rep;
            end
        end
    end

    // Next-state and macro/handshake outputs
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 10'd0;
        mem_wdata = 32'd0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = (req_we && (conf_eff == 3'd0)) ? S_WR : S_RD;
                end
            end
            S_RD: begin
                mem_en    = 1'b1;
                mem_addr  = row_q;
                state_nxt = S_CAP;
            end
            S_CAP: begin
                state_nxt = we_q ? S_WR : S_RSP;
            end
            S_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = row_q;
                mem_wdata = (c_q == 3'd0) ? wdata_q : merge_q;
                state_nxt = S_IDLE;
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb/tb_sram_access_ctrl.sv - randomized bench for sram_access_ctrl against a request-level model
module tb_sram_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        preload = 1'b1;
    logic [2:0]  conf = 3'd0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [14:0] req_addr = 15'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sram_access_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .conf      (conf),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [31:0] init_val(input int i);
        if (i == 1)    return 32'h1122_3344;
        if (i == 2)    return 32'hCAFE_F00D;
        if (i == 1023) return 32'h0000_0000;
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    function automatic int f_c(input logic [2:0] cf);
        return (cf > 3'd5) ? 0 : int'(cf);
    endfunction

    function automatic logic [9:0] f_row(input logic [2:0] cf, input logic [14:0] addr);
        return 10'((int'(addr) >> f_c(cf)) % 1024);
    endfunction

    function automatic logic [31:0] f_rsp(input logic [31:0] word, input logic [2:0] cf, input logic [14:0] addr);
        int c, w, lane;
        logic [63:0] v, r;
        c = f_c(cf);
        w = 32 >> c;
        lane = int'(addr) % (1 << c);
        v = ({32'd0, word} >> (w * lane)) % (64'd1 << w);
        r = '0;
        for (int j = 0; j < 32 / w; j++) r = r + (v << (w * j));
        return r[31:0];
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] word, input logic [2:0] cf, input logic [14:0] addr, input logic [31:0] wd);
        int c, w, lane;
        logic [63:0] m, r;
        c = f_c(cf);
        w = 32 >> c;
        lane = int'(addr) % (1 << c);
        m = (64'd1 << w) - 64'd1;
        r = ({32'd0, word} & ~(m << (w * lane))) | (({32'd0, wd} & m) << (w * lane));
        return r[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Macro model: 1-cycle read latency
    logic [31:0] sram [1024];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) sram[i] <= init_val(i);
        end else if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata <= sram[mem_addr];
        end
    end

    // Request-level model: n counts cycles since accept, kind 0=read 1=narrow write 2=full write
    logic [31:0] model_mem [1024];
    int          n = 0;
    int          kind = 0;
    logic [9:0]  m_row = '0;
    logic [31:0] m_word = '0;
    logic [31:0] m_rsp = '0;
    logic [31:0] last_rsp = '0;

    always @(posedge clk or posedge rst) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) model_mem[i] <= init_val(i);
            n <= 0;
            last_rsp <= '0;
        end else if (rst) begin
            n <= 0;
            last_rsp <= '0;
        end else if (n == 0) begin
            if (req_valid) begin
                n      <= 1;
                kind   <= (req_we && f_c(conf) == 0) ? 2 : (req_we ? 1 : 0);
                m_row  <= f_row(conf, req_addr);
                m_word <= f_merge(model_mem[f_row(conf, req_addr)], conf, req_addr, req_wdata);
                m_rsp  <= f_rsp(model_mem[f_row(conf, req_addr)], conf, req_addr);
            end
        end else begin
            case (kind)
                0: begin
                    if (n == 2) begin
                        last_rsp <= m_rsp;
                        n <= 3;
                    end else if (n >= 3) begin
                        if (rsp_ready) n <= 0;
                    end else begin
                        n <= n + 1;
                    end
                end
                1: begin
                    if (n == 3) begin
                        model_mem[m_row] <= m_word;
                        n <= 0;
                    end else begin
                        n <= n + 1;
                    end
                end
                default: begin
                    model_mem[m_row] <= m_word;
                    n <= 0;
                end
            endcase
        end
    end

    logic e_ready, e_rv, e_rd, e_wr;
    assign e_ready = (n == 0);
    assign e_rv    = (n >= 3) && (kind == 0);
    assign e_rd    = (n == 1) && (kind != 2);
    assign e_wr    = ((n == 1) && (kind == 2)) || ((n == 3) && (kind == 1));

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req_ready", 32'(req_ready), 32'd1);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_rsp_data",  rsp_data, 32'd0);
            chk("rst_mem_en",    32'(mem_en), 32'd0);
            chk("rst_mem_we",    32'(mem_we), 32'd0);
            chk("rst_mem_addr",  32'(mem_addr), 32'd0);
            chk("rst_mem_wdata", mem_wdata, 32'd0);
        end else begin
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
            chk("rsp_data",  rsp_data, last_rsp);
            chk("mem_en",    32'(mem_en), 32'(e_rd | e_wr));
            if (e_rd | e_wr) begin
                chk("mem_we",   32'(mem_we), 32'(e_wr));
                chk("mem_addr", 32'(mem_addr), 32'(m_row));
            end
            if (e_wr) chk("mem_wdata", mem_wdata, m_word);
        end
    end

    task automatic do_req(input logic we, input logic [2:0] cf, input logic [14:0] addr,
                          input logic [31:0] wd, input logic [2:0] cf_after, input int hold,
                          output logic [31:0] rd);
        int t;
        rd = '0;
        req_valid = 1'b1;
        req_we    = we;
        conf      = cf;
        req_addr  = addr;
        req_wdata = wd;
        rsp_ready = (hold == 0);
        t = 0;
        while (t < 50) begin
            @(negedge clk);
            if (req_ready) break;
            t++;
        end
        if (t >= 50) timeout_fail("accept");
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        conf      = cf_after;
        req_we    = 1'($urandom);
        req_addr  = 15'($urandom);
        req_wdata = $urandom;
        if (!we) begin
            t = 0;
            while (t < 50) begin
                @(negedge clk);
                if (rsp_valid) break;
                t++;
            end
            if (t >= 50) timeout_fail("rsp_valid");
            rd = rsp_data;
            repeat (hold) @(negedge clk);
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (t < 50) begin
            @(negedge clk);
            if (req_ready) break;
            t++;
        end
        if (t >= 50) timeout_fail("idle");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        we;
        logic [2:0]  cf;
        logic [14:0] addr;
        int          hold;

        repeat (3) @(posedge clk);
        #1 preload = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;

        chk("model_rsp_pin",   f_rsp(32'h11AB_3344, 3'b010, 15'h0006), 32'hABAB_ABAB);
        chk("model_merge_pin", f_merge(32'h1122_3344, 3'b010, 15'h0006, 32'h0000_00AB), 32'h11AB_3344);
        chk("model_top_pin",   f_merge(32'h0, 3'b101, 15'h7FFF, 32'h1), 32'h8000_0000);

        @(posedge clk);
        #1;
        do_req(1'b1, 3'b000, 15'h0005, 32'hDEAD_BEEF, 3'b000, 0, rd);
        wait_idle();
        chk("full_wr_row5", sram[5], 32'hDEAD_BEEF);
        do_req(1'b0, 3'b000, 15'h0005, 32'h0, 3'b000, 0, rd);
        chk("full_rd_row5", rd, 32'hDEAD_BEEF);

        do_req(1'b1, 3'b010, 15'h0006, 32'h0000_00AB, 3'b010, 0, rd);
        wait_idle();
        chk("narrow8_wr_row1", sram[1], 32'h11AB_3344);
        do_req(1'b0, 3'b010, 15'h0006, 32'h0, 3'b010, 0, rd);
        chk("narrow8_rd", rd, 32'hABAB_ABAB);

        do_req(1'b1, 3'b101, 15'h7FFF, 32'h0000_0001, 3'b101, 0, rd);
        wait_idle();
        chk("bit_wr_row1023", sram[1023], 32'h8000_0000);
        do_req(1'b0, 3'b101, 15'h7FFF, 32'h0, 3'b101, 0, rd);
        chk("bit_rd_7fff", rd, 32'hFFFF_FFFF);
        do_req(1'b0, 3'b101, 15'h7FFE, 32'h0, 3'b101, 0, rd);
        chk("bit_rd_7ffe", rd, 32'h0000_0000);

        do_req(1'b0, 3'b000, 15'h0005, 32'h0, 3'b000, 5, rd);
        chk("backpressure_rd", rd, 32'hDEAD_BEEF);

        do_req(1'b1, 3'b011, 15'h0013, 32'h0000_0005, 3'b011, 0, rd);
        @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        chk("rst_cap_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_cap_row2", sram[2], 32'hCAFE_F00D);
        do_req(1'b0, 3'b000, 15'h0002, 32'h0, 3'b000, 0, rd);
        chk("rst_cap_readback", rd, 32'hCAFE_F00D);

        do_req(1'b0, 3'b110, 15'h0005, 32'h0, 3'b110, 0, rd);
        chk("conf110_rd", rd, 32'hDEAD_BEEF);
        do_req(1'b0, 3'b000, 15'h0005, 32'h0, 3'b101, 0, rd);
        chk("conf_change_rd", rd, 32'hDEAD_BEEF);

        for (int k = 0; k < 300; k++) begin
            we = 1'($urandom_range(0, 1));
            cf = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0:       addr = 15'h7FFF;
                1:       addr = 15'h0000;
                default: addr = 15'($urandom);
            endcase
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            do_req(we, cf, addr, $urandom, 3'($urandom_range(0, 7)), hold, rd);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        wait_idle();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
